// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the KGP multiply sequencer and the
// hazard unit that stalls on it.
package mul_seq_pkg;

  localparam int MUL_WIDTH   = 32;
  localparam int MUL_LATENCY = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mul_state_t;

endpackage

// File: rtl/unsignedmultiplication.sv
// Combinational unsigned multiplier. The sequencer gives it a full clock
// cycle, from registered operands to a registered product.
module unsignedmultiplication #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  assign p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

endmodule

// File: rtl/mul_sequencer.sv
// Multicycle mult/multu controller: magnitude conversion, one multiplier
// cycle, sign correction into HI/LO, with busy/done handshake and kill.
module mul_sequencer
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             kill,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mul_state_t           state_reg, state_next;
  logic [WIDTH-1:0]     mag_a_reg, mag_a_next;
  logic [WIDTH-1:0]     mag_b_reg, mag_b_next;
  logic                 neg_reg, neg_next;
  logic [2*WIDTH-1:0]   prod_reg, prod_next;
  logic [2*WIDTH-1:0]   result_reg, result_next;
  logic [2*WIDTH-1:0]   mul_p;

  unsignedmultiplication #(.WIDTH(WIDTH)) u_mul (
    .a (mag_a_reg),
    .b (mag_b_reg),
    .p (mul_p)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      mag_a_reg  <= '0;
      mag_b_reg  <= '0;
      neg_reg    <= 1'b0;
      prod_reg   <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      mag_a_reg  <= mag_a_next;
      mag_b_reg  <= mag_b_next;
      neg_reg    <= neg_next;
      prod_reg   <= prod_next;
      result_reg <= result_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    mag_a_next  = mag_a_reg;
    mag_b_next  = mag_b_reg;
    neg_next    = neg_reg;
    prod_next   = prod_reg;
    result_next = result_reg;
    ready       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    unique case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude
          mag_a_next = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
          mag_b_next = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
          neg_next   = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          state_next = MUL;
        end
      end
      MUL: begin
        busy       = 1'b1;
        prod_next  = mul_p;
        state_next = FIX;
      end
      FIX: begin
        busy        = 1'b1;
        result_next = neg_reg ? -prod_reg : prod_reg;
        state_next  = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // A flush drops any captured request and blocks the FIX write
    if (kill) begin
      state_next  = IDLE;
      mag_a_next  = mag_a_reg;
      mag_b_next  = mag_b_reg;
      neg_next    = neg_reg;
      prod_next   = prod_reg;
      result_next = result_reg;
    end
  end

  assign hi = result_reg[2*WIDTH-1:WIDTH];
  assign lo = result_reg[WIDTH-1:0];

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed and random checks of mul_sequencer against a plain-arithmetic
// 64-bit product model.
module tb_mul_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         kill;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_assert = 0;
  int n_fail   = 0;

  mul_sequencer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .kill      (kill),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    longint sa;
    longint sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    return 64'(sa * sb);
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [63:0] exp;
    exp = model(a, b, s);
    check("ready_c0", ready, 1);
    start = 1'b1; is_signed = s; op_a = a; op_b = b;
    step();
    start = 1'b0; op_a = $urandom; op_b = $urandom; is_signed = ~s;
    for (int c = 1; c < mul_seq_pkg::MUL_LATENCY; c++) begin
      check("busy_mid", busy, 1);
      check("done_early", done, 0);
      step();
    end
    check("done_c3", done, 1);
    check("hi", hi, exp[63:32]);
    check("lo", lo, exp[31:0]);
    $display("op a=%h b=%h signed=%0d -> hi=%h lo=%h (model %h)", a, b, s, hi, lo, exp);
    step();
    check("ready_c4", ready, 1);
    check("done_c4", done, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0; kill = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hilo", {hi, lo}, 64'd0);
    $display("reset: ready=%0d busy=%0d done=%0d hi=%h lo=%h", ready, busy, done, hi, lo);

    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check("u_max", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op(32'hFFFFFFFD, 32'd5, 1'b1);
    check("s_m3x5", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    run_op(32'h80000000, 32'h80000000, 1'b1);
    check("s_minsq", {hi, lo}, 64'h40000000_00000000);
    run_op(32'h80000000, 32'd1, 1'b1);
    check("s_minx1", {hi, lo}, 64'hFFFFFFFF_80000000);
    run_op(32'd0, 32'hFFFFFFF0, 1'b1);
    check("s_zero_neg", {hi, lo}, 64'd0);

    // second start while busy is ignored
    start = 1'b1; is_signed = 1'b0; op_a = 32'd7; op_b = 32'd6;
    step();
    op_a = 32'd9; op_b = 32'd9;
    check("busy_ready_c1", ready, 0);
    step();
    start = 1'b0;
    step();
    check("busy_done", done, 1);
    check("busy_result", {hi, lo}, 64'd42);
    $display("busy test: hi=%h lo=%h", hi, lo);
    step();
    check("busy_nostart", ready, 1);

    // kill in FIX
    run_op(32'd7, 32'd6, 1'b0);
    start = 1'b1; op_a = 32'd3; op_b = 32'd3; is_signed = 1'b0;
    step();
    start = 1'b0;
    step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    check("kill_ready", ready, 1);
    check("kill_done", done, 0);
    check("kill_hilo", {hi, lo}, 64'd42);
    step();
    check("kill_nodone", done, 0);
    check("kill_hilo2", {hi, lo}, 64'd42);
    $display("kill in FIX: ready=%0d hi=%h lo=%h", ready, hi, lo);

    // kill together with start in IDLE drops the request
    start = 1'b1; kill = 1'b1; op_a = 32'd5; op_b = 32'd5;
    step();
    start = 1'b0; kill = 1'b0;
    check("killstart_ready", ready, 1);
    step(); step();
    check("killstart_done", done, 0);
    check("killstart_hilo", {hi, lo}, 64'd42);
    $display("kill with start: ready=%0d hi=%h lo=%h", ready, hi, lo);

    // reset mid-operation
    start = 1'b1; op_a = 32'd11; op_b = 32'd13;
    step();
    start = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_ready", ready, 1);
    check("rstmid_busy", busy, 0);
    check("rstmid_done", done, 0);
    check("rstmid_hilo", {hi, lo}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rstmid_nodone", done, 0);
    end
    $display("reset in MUL: ready=%0d busy=%0d hi=%h lo=%h", ready, busy, hi, lo);

    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = $urandom;
      b = $urandom;
      if (i % 6 == 0) a = 32'h80000000;
      if (i % 8 == 3) b = 32'h0;
      run_op(a, b, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
